// File: rtl/logic_unit_if.sv
// rtl/logic_unit_if.sv - operand/result handshake bundle for the pipelined logic unit
interface logic_unit_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] y;
  logic                  zero;
  logic                  parity;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, zero, parity
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, zero, parity
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - registered bitwise logic stage with valid/ready and optional skid entry
module logic_unit_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter bit SKID       = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  logic_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_in_ready;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_drain;
  logic                  w_load_main;
  logic                  w_main_from_skid;
  logic                  w_load_skid;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_zero;
  logic                  w_parity;
  logic [DATA_WIDTH-1:0] r_main_y;
  logic                  r_main_zero;
  logic                  r_main_parity;
  logic [DATA_WIDTH-1:0] r_skid_y;
  logic                  r_skid_zero;
  logic                  r_skid_parity;

  always_comb begin
    w_result = '0;
    case (bus.op)
      3'b000:  w_result = ~bus.a;
      3'b001:  w_result = bus.a & bus.b;
      3'b010:  w_result = bus.a | bus.b;
      3'b011:  w_result = bus.a ^ bus.b;
      3'b100:  w_result = ~(bus.a & bus.b);
      3'b101:  w_result = ~(bus.a | bus.b);
      3'b110:  w_result = ~(bus.a ^ bus.b);
      default: w_result = bus.a;
    endcase
  end

  assign w_zero   = (w_result == '0);
  assign w_parity = ^w_result;

  // Without the skid entry the stage can only accept when its one slot frees this cycle.
  assign w_in_ready = SKID ? r_in_ready : ((r_state == S_EMPTY) | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_drain    = (r_state != S_EMPTY) & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_TWO);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) w_next = S_ONE;
      end
      S_ONE: begin
        if (w_accept && !w_drain && SKID) w_next = S_TWO;
        else if (w_drain && !w_accept)    w_next = S_EMPTY;
      end
      S_TWO: begin
        if (w_drain) w_next = S_ONE;
      end
      default: w_next = S_EMPTY;
    endcase
  end

  always_comb begin
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: w_load_main = w_accept;
      S_ONE: begin
        w_load_main = w_accept & w_drain;
        w_load_skid = w_accept & ~w_drain;
      end
      S_TWO: begin
        w_load_main      = w_drain;
        w_main_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  // Flags travel with the result so they always match the y being presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_y      <= '0;
      r_main_zero   <= 1'b0;
      r_main_parity <= 1'b0;
    end else if (w_load_main) begin
      if (w_main_from_skid) begin
        r_main_y      <= r_skid_y;
        r_main_zero   <= r_skid_zero;
        r_main_parity <= r_skid_parity;
      end else begin
        r_main_y      <= w_result;
        r_main_zero   <= w_zero;
        r_main_parity <= w_parity;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_y      <= '0;
      r_skid_zero   <= 1'b0;
      r_skid_parity <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_y      <= w_result;
      r_skid_zero   <= w_zero;
      r_skid_parity <= w_parity;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state != S_EMPTY);
  assign bus.y         = r_main_y;
  assign bus.zero      = r_main_zero;
  assign bus.parity    = r_main_parity;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - scoreboard bench for logic_unit_pipe (skid W=8, no-skid W=1 and W=32)
module tb_logic_unit_pipe;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       p;
  } exp_t;

  logic clk;
  logic rst;

  logic_unit_if #(.DATA_WIDTH(8))  m ();
  logic_unit_if #(.DATA_WIDTH(1))  n1 ();
  logic_unit_if #(.DATA_WIDTH(32)) n32 ();

  logic_unit_pipe #(.DATA_WIDTH(8),  .SKID(1'b1)) u_skid (.clk(clk), .rst(rst), .bus(m));
  logic_unit_pipe #(.DATA_WIDTH(1),  .SKID(1'b0)) u_w1   (.clk(clk), .rst(rst), .bus(n1));
  logic_unit_pipe #(.DATA_WIDTH(32), .SKID(1'b0)) u_w32  (.clk(clk), .rst(rst), .bus(n32));

  int   n_vec;
  int   n_err;
  int   stall_cnt;
  bit   rand_done;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    case (op)
      3'd0: e.y = ~a;
      3'd1: e.y = a & b;
      3'd2: e.y = a | b;
      3'd3: e.y = a ^ b;
      3'd4: e.y = ~(a & b);
      3'd5: e.y = ~(a | b);
      3'd6: e.y = ~(a ^ b);
      default: e.y = a;
    endcase
    e.z = (e.y == 8'h00);
    e.p = ^e.y;
    return e;
  endfunction

  // Offers one vector and waits (bounded) for it to be accepted; returns just after the accepting edge.
  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
    bit ok;
    ok = 1'b0;
    m.op = op;
    m.a = a;
    m.b = b;
    m.in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (m.in_ready) begin
        ok = 1'b1;
        break;
      end
      stall_cnt++;
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m.out_valid && m.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_y",      {24'd0, m.y},      {24'd0, e.y});
        check("sb_zero",   {31'd0, m.zero},   {31'd0, e.z});
        check("sb_parity", {31'd0, m.parity}, {31'd0, e.p});
      end
    end
  end

  initial begin
    logic [7:0] ops_tbl [8];
    logic [3:0] w1_exp;
    n_vec = 0;
    n_err = 0;
    stall_cnt = 0;
    rand_done = 1'b0;
    ops_tbl = '{8'h5A, 8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA5};
    w1_exp = 4'b1001;
    rst = 1'b1;
    m.in_valid = 1'b0;  m.op = '0;  m.a = '0;  m.b = '0;  m.out_ready = 1'b0;
    n1.in_valid = 1'b0; n1.op = '0; n1.a = '0; n1.b = '0; n1.out_ready = 1'b0;
    n32.in_valid = 1'b0; n32.op = '0; n32.a = '0; n32.b = '0; n32.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, m.out_valid}, 32'd0);
    check("rst_y",         {24'd0, m.y},         32'd0);
    check("rst_zero",      {31'd0, m.zero},      32'd0);
    check("rst_parity",    {31'd0, m.parity},    32'd0);
    check("rst_in_ready",  {31'd0, m.in_ready},  32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two results held under stall, then asynchronous reset discards them.
    m.out_ready = 1'b0;
    drive(3'd7, 8'h11, 8'h00, model(3'd7, 8'h11, 8'h00));
    drive(3'd7, 8'h22, 8'h00, model(3'd7, 8'h22, 8'h00));
    m.in_valid = 1'b0;
    check("held_two_in_ready", {31'd0, m.in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, m.out_valid}, 32'd0);
    check("midrst_y",         {24'd0, m.y},         32'd0);
    check("midrst_in_ready",  {31'd0, m.in_ready},  32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All eight ops back-to-back, latency one clock.
    m.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.y = ops_tbl[i];
      e.z = (ops_tbl[i] == 8'h00);
      e.p = ^ops_tbl[i];
      drive(i[2:0], 8'hA5, 8'h0F, e);
      check("lat_out_valid", {31'd0, m.out_valid}, 32'd1);
      check("lat_y",         {24'd0, m.y},         {24'd0, ops_tbl[i]});
    end
    m.in_valid = 1'b0;

    drive(3'd3, 8'h3C, 8'h3C, '{y: 8'h00, z: 1'b1, p: 1'b0});
    drive(3'd0, 8'hFE, 8'h00, '{y: 8'h01, z: 1'b0, p: 1'b1});
    m.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Stall: two fit, the third is refused until downstream drains.
    m.out_ready = 1'b0;
    drive(3'd7, 8'h01, 8'h00, '{y: 8'h01, z: 1'b0, p: 1'b1});
    drive(3'd7, 8'h02, 8'h00, '{y: 8'h02, z: 1'b0, p: 1'b1});
    m.a = 8'h03;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, m.in_ready}, 32'd0);
      check("stall_y",        {24'd0, m.y},        32'h01);
    end
    @(posedge clk);
    #1;
    m.out_ready = 1'b1;
    drive(3'd7, 8'h03, 8'h00, '{y: 8'h03, z: 1'b0, p: 1'b0});
    m.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stall_drained", exp_q.size(), 32'd0);

    // Full throughput: in_ready must never drop.
    stall_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      drive(op, a, b, model(op, a, b));
    end
    m.in_valid = 1'b0;
    check("throughput_stalls", stall_cnt, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Random backpressure, ordered scoreboard.
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [2:0] op;
          logic [7:0] a;
          logic [7:0] b;
          op = 3'($urandom_range(0, 7));
          a = 8'($urandom);
          b = 8'($urandom);
          drive(op, a, b, model(op, a, b));
        end
        m.in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          m.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("random_drained", exp_q.size(), 32'd0);

    // No-skid, 32-bit: ops 2 and 5, in_ready tracks out_ready combinationally.
    n32.a = 32'hF0F0_1234;
    n32.b = 32'h0F0F_0001;
    n32.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      n32.op = (k == 0) ? 3'd2 : 3'd5;
      n32.in_valid = 1'b1;
      @(posedge clk);
      #1;
      n32.in_valid = 1'b0;
      check("w32_out_valid", {31'd0, n32.out_valid}, 32'd1);
      check("w32_y", n32.y, (k == 0) ? 32'hFFFF_1235 : 32'h0000_EDCA);
      n32.out_ready = 1'b0;
      #1;
      check("w32_in_ready_lo", {31'd0, n32.in_ready}, 32'd0);
      n32.out_ready = 1'b1;
      #1;
      check("w32_in_ready_hi", {31'd0, n32.in_ready}, 32'd1);
      @(posedge clk);
      #1;
    end

    // No-skid, 1-bit: ops 2 and 5 with b=0 and a=1/0.
    n1.out_ready = 1'b1;
    n1.b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n1.op = i[0] ? 3'd5 : 3'd2;
      n1.a = ~i[1];
      n1.in_valid = 1'b1;
      @(posedge clk);
      #1;
      n1.in_valid = 1'b0;
      check("w1_y",    {31'd0, n1.y},    {31'd0, w1_exp[i]});
      check("w1_zero", {31'd0, n1.zero}, {31'd0, ~w1_exp[i]});
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
